l2_port_arbiter: RTL and testbench
==================================

// Module: l2_port_arbiter
// PURPOSE
//  Shares the single L2 cache port between two L1 requesters (r0 = L1 instruction, r1 = L1 data).
//  Each requester side is a drop-in for an L1's L2 interface: level read/write held until ready.
//  Round-robin grant; one transaction in flight; registered request path; combinational return path to the owner.
// PARAMETERS
//  ADDR_WIDTH  32  address width, all ports
//  DATA_WIDTH  32  data width, all ports
//  CNT_WIDTH   16  perf counter width (used only with L2_ARB_PERF_CNT_EN)
// PORTS
//  clk                  in   1           clock, rising edge
//  rst_n                in   1           reset, asynchronous, active-low
//  r0_addr / r1_addr    in   ADDR_WIDTH  requester address
//  r0_wdata / r1_wdata  in   DATA_WIDTH  requester write data
//  r0_read / r1_read    in   1           read request, held until rN_ready
//  r0_write / r1_write  in   1           write request, held until rN_ready
//  r0_rdata / r1_rdata  out  DATA_WIDTH  l2_rdata when owner, else 0
//  r0_ready / r1_ready  out  1           1-cycle completion pulse to owner
//  r0_hit / r1_hit      out  1           l2_hit when owner, else 0
//  l2_addr              out  ADDR_WIDTH  registered address to L2
//  l2_wdata             out  DATA_WIDTH  registered write data to L2
//  l2_read / l2_write   out  1           registered L2 strobes, held until l2_ready
//  l2_rdata             in   DATA_WIDTH  L2 read data
//  l2_ready / l2_hit    in   1           L2 completion / hit
//  busy                 out  1           1 in ISSUE or RELEASE
//  grant_id             out  1           current/last owner
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; last_grant=1 (r0 wins first tie). Async reset mid-transaction aborts it; no ready pulse.
//  States: IDLE -> ISSUE -> RELEASE -> IDLE.
//  IDLE: req_n = rN_read|rN_write. One requesting -> grant it; both -> grant !last_grant.
//   On grant edge: latch addr/wdata into l2_addr/l2_wdata, assert l2_write if rN_write else l2_read, grant_id<=n, -> ISSUE.
//   read&write together = write (illegal; bench does not drive except in scenario 5).
//  ISSUE: L2 outputs held stable; requester input changes ignored. r<grant>_rdata/_hit follow L2 combinationally.
//   l2_ready=1 -> r<grant>_ready=1 same cycle; at that edge clear l2_read/l2_write, last_grant<=grant_id, -> RELEASE.
//  RELEASE: exactly 1 cycle, no grant (owner still drives its request the cycle after ready). -> IDLE.
//  Latency: request seen cycle N -> l2 strobe cycle N+1; ready returned same cycle as l2_ready;
//   next grant earliest 2 cycles after ready. Back-to-back alternation when both hold requests.
//  Non-owner rN_ready/rN_hit/rN_rdata always 0. l2_hit passed through only while ISSUE.
//  l2_ready outside ISSUE is ignored.
// CONFIGURATION
//  L2_ARB_PERF_CNT_EN defined: extra outputs gnt_cnt0/gnt_cnt1/wait_cnt0/wait_cnt1 [CNT_WIDTH-1:0], reset 0.
//   gnt_cntN +1 per grant to N; wait_cntN +1 per cycle N requests while not owner in ISSUE/RELEASE, or loses a tie.
//   Saturate at all-ones (no wrap).
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Package l2_arb_pkg: state enum (IDLE/ISSUE/RELEASE, 2-bit), REQ_IFETCH=0, REQ_DATA=1 constants.
//  Sub-module l2_rr_arb2: inputs req[1:0], last_grant; outputs gnt_valid, gnt_id (combinational pick).
//  FSM, latch registers, return mux and optional counters stay in l2_port_arbiter.
// TESTING
//  1 r0_read addr=0x100, L2 ready after 3 cycles rdata=0xDEADBEEF hit=1 -> l2_read 1 cycle later, r0_ready pulse, r0_rdata=0xDEADBEEF, r0_hit=1.
//  2 r0 and r1 read same cycle from reset -> r0 served first, r1 granted 2 cycles after r0_ready; r1 never sees ready early.
//  3 r1_write addr=0x40 wdata=0x1234 -> l2_write=1, l2_wdata=0x1234, l2_read=0; r1_ready on l2_ready.
//  4 rst_n low during ISSUE -> all outputs 0 immediately; after release, r0 held request re-granted, no stale ready.
//  5 r0 read+write together -> l2_write only; spurious l2_ready in IDLE -> no rN_ready.
//  6 PERF_CNT_EN: 5 alternating contended reads -> gnt_cnt0=3, gnt_cnt1=2; force CNT_WIDTH=2 -> counters stop at 3.

Source files
------------

// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 port arbiter.
package l2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam logic REQ_IFETCH = 1'b0;
  localparam logic REQ_DATA   = 1'b1;

endpackage

// File: rtl/l2_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not granted last.
module l2_rr_arb2
  import l2_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = REQ_IFETCH;
    case (req)
      2'b10:   gnt_id = REQ_DATA;
      2'b11:   gnt_id = ~last_grant;
      default: gnt_id = REQ_IFETCH;
    endcase
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares one L2 port between the L1 instruction (r0) and L1 data (r1) requesters.
// Optional saturating grant/wait counters are built when L2_ARB_PERF_CNT_EN is defined.
module l2_port_arbiter
  import l2_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  input  logic                  r0_read,
  input  logic                  r0_write,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  output logic                  r0_ready,
  output logic                  r0_hit,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  input  logic                  r1_read,
  input  logic                  r1_write,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  r1_ready,
  output logic                  r1_hit,
  output logic [ADDR_WIDTH-1:0] l2_addr,
  output logic [DATA_WIDTH-1:0] l2_wdata,
  output logic                  l2_read,
  output logic                  l2_write,
  input  logic [DATA_WIDTH-1:0] l2_rdata,
  input  logic                  l2_ready,
  input  logic                  l2_hit,
  output logic                  busy,
`ifdef L2_ARB_PERF_CNT_EN
  output logic [CNT_WIDTH-1:0]  gnt_cnt0,
  output logic [CNT_WIDTH-1:0]  gnt_cnt1,
  output logic [CNT_WIDTH-1:0]  wait_cnt0,
  output logic [CNT_WIDTH-1:0]  wait_cnt1,
`endif
  output logic                  grant_id
);

  if (CNT_WIDTH < 1) begin : g_cnt_width_chk
    $error("CNT_WIDTH must be at least 1");
  end

  arb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] l2_addr_q, l2_addr_d;
  logic [DATA_WIDTH-1:0] l2_wdata_q, l2_wdata_d;
  logic                  l2_read_q, l2_read_d;
  logic                  l2_write_q, l2_write_d;
  logic                  grant_id_q, grant_id_d;
  logic                  last_grant_q, last_grant_d;

  logic [1:0] req;
  logic       gnt_valid;
  logic       gnt_id;
  logic       in_issue;
  logic       own0, own1;

  assign req = {r1_read | r1_write, r0_read | r0_write};

  l2_rr_arb2 u_rr (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      l2_addr_q    <= '0;
      l2_wdata_q   <= '0;
      l2_read_q    <= 1'b0;
      l2_write_q   <= 1'b0;
      grant_id_q   <= REQ_IFETCH;
      last_grant_q <= REQ_DATA;
    end else begin
      state_q      <= state_d;
      l2_addr_q    <= l2_addr_d;
      l2_wdata_q   <= l2_wdata_d;
      l2_read_q    <= l2_read_d;
      l2_write_q   <= l2_write_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Grant in IDLE, hold the L2 request through ISSUE, one dead cycle in RELEASE.
  always_comb begin
    state_d      = state_q;
    l2_addr_d    = l2_addr_q;
    l2_wdata_d   = l2_wdata_q;
    l2_read_d    = l2_read_q;
    l2_write_d   = l2_write_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d    = ISSUE;
          grant_id_d = gnt_id;
          if (gnt_id == REQ_DATA) begin
            l2_addr_d  = r1_addr;
            l2_wdata_d = r1_wdata;
            l2_write_d = r1_write;
            l2_read_d  = ~r1_write;
          end else begin
            l2_addr_d  = r0_addr;
            l2_wdata_d = r0_wdata;
            l2_write_d = r0_write;
            l2_read_d  = ~r0_write;
          end
        end
      end
      ISSUE: begin
        if (l2_ready) begin
          state_d      = RELEASE;
          l2_read_d    = 1'b0;
          l2_write_d   = 1'b0;
          last_grant_d = grant_id_q;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Return path is live only for the owner while its transaction is at L2.
  assign in_issue = (state_q == ISSUE);
  assign own0     = in_issue & (grant_id_q == REQ_IFETCH);
  assign own1     = in_issue & (grant_id_q == REQ_DATA);

  assign r0_ready = own0 & l2_ready;
  assign r0_hit   = own0 & l2_hit;
  assign r0_rdata = own0 ? l2_rdata : '0;
  assign r1_ready = own1 & l2_ready;
  assign r1_hit   = own1 & l2_hit;
  assign r1_rdata = own1 ? l2_rdata : '0;

  assign l2_addr  = l2_addr_q;
  assign l2_wdata = l2_wdata_q;
  assign l2_read  = l2_read_q;
  assign l2_write = l2_write_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q == ISSUE) | (state_q == RELEASE);

`ifdef L2_ARB_PERF_CNT_EN
  logic [1:0][CNT_WIDTH-1:0] gnt_cnt_q, gnt_cnt_d;
  logic [1:0][CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]                gnt_inc, wait_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      gnt_cnt_q  <= gnt_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // A requester waits while someone else owns the port, or when it loses a tie.
  always_comb begin
    gnt_cnt_d  = gnt_cnt_q;
    wait_cnt_d = wait_cnt_q;
    gnt_inc    = '0;
    wait_inc   = '0;
    for (int n = 0; n < 2; n++) begin
      gnt_inc[n]  = (state_q == IDLE) & gnt_valid & (gnt_id == 1'(n));
      wait_inc[n] = req[n] & ((busy & (grant_id_q != 1'(n))) |
                              ((state_q == IDLE) & (&req) & (gnt_id != 1'(n))));
      if (gnt_inc[n] && (gnt_cnt_q[n] != '1)) begin
        gnt_cnt_d[n] = gnt_cnt_q[n] + CNT_WIDTH'(1);
      end
      if (wait_inc[n] && (wait_cnt_q[n] != '1)) begin
        wait_cnt_d[n] = wait_cnt_q[n] + CNT_WIDTH'(1);
      end
    end
  end

  assign gnt_cnt0  = gnt_cnt_q[0];
  assign gnt_cnt1  = gnt_cnt_q[1];
  assign wait_cnt0 = wait_cnt_q[0];
  assign wait_cnt1 = wait_cnt_q[1];
`endif

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model; counter checks are built when L2_ARB_PERF_CNT_EN is defined.
module tb_l2_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] r0_addr, r1_addr, l2_addr;
  logic [DW-1:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata, l2_wdata, l2_rdata;
  logic          r0_read, r0_write, r0_ready, r0_hit;
  logic          r1_read, r1_write, r1_ready, r1_hit;
  logic          l2_read, l2_write, l2_ready, l2_hit;
  logic          busy, grant_id;
`ifdef L2_ARB_PERF_CNT_EN
  logic [CW-1:0] gnt_cnt0, gnt_cnt1, wait_cnt0, wait_cnt1;
`endif

  l2_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_read(r0_read), .r0_write(r0_write),
    .r0_rdata(r0_rdata), .r0_ready(r0_ready), .r0_hit(r0_hit),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_read(r1_read), .r1_write(r1_write),
    .r1_rdata(r1_rdata), .r1_ready(r1_ready), .r1_hit(r1_hit),
    .l2_addr(l2_addr), .l2_wdata(l2_wdata), .l2_read(l2_read), .l2_write(l2_write),
    .l2_rdata(l2_rdata), .l2_ready(l2_ready), .l2_hit(l2_hit),
    .busy(busy),
`ifdef L2_ARB_PERF_CNT_EN
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .wait_cnt0(wait_cnt0), .wait_cnt1(wait_cnt1),
`endif
    .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a transaction is either at L2, in its cool-down cycle, or absent.
  logic          m_at_l2, m_cool, m_last, m_owner, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_gnt[2], m_wait[2];
  localparam int CNT_MAX = (1 << CW) - 1;

  task automatic model_reset();
    m_at_l2 = 1'b0; m_cool = 1'b0; m_last = 1'b1; m_owner = 1'b0; m_wr = 1'b0;
    m_addr = '0; m_wdata = '0;
    m_gnt[0] = 0; m_gnt[1] = 0; m_wait[0] = 0; m_wait[1] = 0;
  endtask

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Single compare process: checks every output each cycle, then advances the model.
  always @(negedge clk) begin
    logic q0, q1, own0, own1, win;
    if (!rst_n) model_reset();
    own0 = m_at_l2 && (m_owner == 1'b0);
    own1 = m_at_l2 && (m_owner == 1'b1);
    chk("l2_addr",  l2_addr,  m_addr);
    chk("l2_wdata", l2_wdata, m_wdata);
    chk("l2_read",  l2_read,  m_at_l2 && !m_wr);
    chk("l2_write", l2_write, m_at_l2 && m_wr);
    chk("busy",     busy,     m_at_l2 || m_cool);
    chk("grant_id", grant_id, m_owner);
    chk("r0_ready", r0_ready, own0 && l2_ready);
    chk("r1_ready", r1_ready, own1 && l2_ready);
    chk("r0_hit",   r0_hit,   own0 && l2_hit);
    chk("r1_hit",   r1_hit,   own1 && l2_hit);
    chk("r0_rdata", r0_rdata, own0 ? l2_rdata : '0);
    chk("r1_rdata", r1_rdata, own1 ? l2_rdata : '0);
`ifdef L2_ARB_PERF_CNT_EN
    chk("gnt_cnt0",  gnt_cnt0,  m_gnt[0]);
    chk("gnt_cnt1",  gnt_cnt1,  m_gnt[1]);
    chk("wait_cnt0", wait_cnt0, m_wait[0]);
    chk("wait_cnt1", wait_cnt1, m_wait[1]);
`endif
    if (rst_n) begin
      q0 = r0_read || r0_write;
      q1 = r1_read || r1_write;
      if (m_at_l2 || m_cool) begin
        if (q0 && m_owner != 1'b0) m_wait[0] = sat(m_wait[0]);
        if (q1 && m_owner != 1'b1) m_wait[1] = sat(m_wait[1]);
      end
      if (m_at_l2) begin
        if (l2_ready) begin
          m_at_l2 = 1'b0; m_cool = 1'b1; m_last = m_owner;
        end
      end else if (m_cool) begin
        m_cool = 1'b0;
      end else if (q0 || q1) begin
        win = (q0 && q1) ? !m_last : !q0;
        if (q0 && q1) m_wait[!win] = sat(m_wait[!win]);
        m_gnt[win] = sat(m_gnt[win]);
        m_at_l2 = 1'b1;
        m_owner = win;
        m_addr  = win ? r1_addr  : r0_addr;
        m_wdata = win ? r1_wdata : r0_wdata;
        m_wr    = win ? r1_write : r0_write;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int n, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (n == 0) begin
      r0_read = rd; r0_write = wr; r0_addr = a; r0_wdata = d;
    end else begin
      r1_read = rd; r1_write = wr; r1_addr = a; r1_wdata = d;
    end
  endtask

  logic rq_on[2], rq_done[2], rdy_seen[2];
  int   l2_wait;

  initial begin
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    l2_ready = 1'b0; l2_hit = 1'b0; l2_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_l2_read", l2_read, 1'b0);

    // Scenario 1: simple read
    step(); set_req(0, 1'b1, 1'b0, 32'h100, '0);
    @(negedge clk); chk("s1_no_strobe_yet", l2_read, 1'b0);
    step();
    @(negedge clk); chk("s1_l2_read", l2_read, 1'b1); chk("s1_l2_addr", l2_addr, 32'h100);
    step();
    step(); l2_ready = 1'b1; l2_rdata = 32'hDEADBEEF; l2_hit = 1'b1;
    @(negedge clk);
    chk("s1_r0_ready", r0_ready, 1'b1);
    chk("s1_r0_rdata", r0_rdata, 32'hDEADBEEF);
    chk("s1_r0_hit", r0_hit, 1'b1);
    chk("s1_r1_rdata", r1_rdata, 32'h0);
    step(); l2_ready = 1'b0; l2_hit = 1'b0; l2_rdata = '0;
    @(negedge clk); chk("s1_release_busy", busy, 1'b1); chk("s1_release_ready", r0_ready, 1'b0);
    step(); set_req(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk); chk("s1_idle", busy, 1'b0);

    // Scenario 2: simultaneous reads from reset
    do_reset();
    step(); set_req(0, 1'b1, 1'b0, 32'h200, '0); set_req(1, 1'b1, 1'b0, 32'h300, '0);
    step();
    @(negedge clk); chk("s2_first_gid", grant_id, 1'b0); chk("s2_first_addr", l2_addr, 32'h200);
    step(); l2_ready = 1'b1; l2_rdata = 32'hA5A5;
    @(negedge clk); chk("s2_r0_ready", r0_ready, 1'b1); chk("s2_r1_not_ready", r1_ready, 1'b0);
    step(); l2_ready = 1'b0;
    step(); set_req(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk); chk("s2_gap_no_strobe", l2_read, 1'b0);
    step();
    @(negedge clk);
    chk("s2_second_strobe", l2_read, 1'b1);
    chk("s2_second_gid", grant_id, 1'b1);
    chk("s2_second_addr", l2_addr, 32'h300);
    step(); l2_ready = 1'b1;
    @(negedge clk); chk("s2_r1_ready", r1_ready, 1'b1);
    step(); l2_ready = 1'b0;
    step(); set_req(1, 1'b0, 1'b0, '0, '0);

    // Scenario 3: data-side write
    step(); set_req(1, 1'b0, 1'b1, 32'h40, 32'h1234);
    step(); l2_ready = 1'b1;
    @(negedge clk);
    chk("s3_l2_write", l2_write, 1'b1);
    chk("s3_l2_read", l2_read, 1'b0);
    chk("s3_l2_wdata", l2_wdata, 32'h1234);
    chk("s3_l2_addr", l2_addr, 32'h40);
    chk("s3_r1_ready", r1_ready, 1'b1);
    step(); l2_ready = 1'b0;
    step(); set_req(1, 1'b0, 1'b0, '0, '0);

    // Scenario 4: reset mid-transaction
    step(); set_req(0, 1'b1, 1'b0, 32'h500, '0);
    step(); rst_n = 1'b0; l2_ready = 1'b1;
    @(negedge clk);
    chk("s4_rst_l2_read", l2_read, 1'b0);
    chk("s4_rst_busy", busy, 1'b0);
    chk("s4_rst_ready", r0_ready, 1'b0);
    chk("s4_rst_addr", l2_addr, 32'h0);
    step(); rst_n = 1'b1; l2_ready = 1'b0;
    @(negedge clk); chk("s4_post_rst_idle", busy, 1'b0);
    step();
    @(negedge clk); chk("s4_regrant", l2_read, 1'b1); chk("s4_regrant_addr", l2_addr, 32'h500);
    step(); l2_ready = 1'b1;
    @(negedge clk); chk("s4_r0_ready", r0_ready, 1'b1);
    step(); l2_ready = 1'b0;
    step(); set_req(0, 1'b0, 1'b0, '0, '0);

    // Scenario 5: read+write together, then spurious l2_ready while idle
    step(); set_req(0, 1'b1, 1'b1, 32'h600, 32'h77);
    step(); l2_ready = 1'b1;
    @(negedge clk); chk("s5_write_only", l2_write, 1'b1); chk("s5_no_read", l2_read, 1'b0);
    step(); l2_ready = 1'b0;
    step(); set_req(0, 1'b0, 1'b0, '0, '0);
    step(); l2_ready = 1'b1;
    @(negedge clk); chk("s5_spur_r0", r0_ready, 1'b0); chk("s5_spur_r1", r1_ready, 1'b0);
    step(); l2_ready = 1'b0;
    @(negedge clk); chk("s5_spur_idle", busy, 1'b0);

`ifdef L2_ARB_PERF_CNT_EN
    // Scenario 6: five alternating contended reads
    do_reset();
    step(); set_req(0, 1'b1, 1'b0, 32'h10, '0); set_req(1, 1'b1, 1'b0, 32'h20, '0);
    for (int k = 0; k < 5; k++) begin
      step(); l2_ready = 1'b1;
      step(); l2_ready = 1'b0;
      if (k < 4) step();
    end
    step(); set_req(0, 1'b0, 1'b0, '0, '0); set_req(1, 1'b0, 1'b0, '0, '0);
    step();
    @(negedge clk); chk("s6_gnt_cnt0", gnt_cnt0, 3); chk("s6_gnt_cnt1", gnt_cnt1, 2);
`endif

    // Randomized traffic
    for (int n = 0; n < 2; n++) begin
      rq_on[n] = 1'b0; rq_done[n] = 1'b0; rdy_seen[n] = 1'b0;
    end
    l2_wait = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      for (int n = 0; n < 2; n++) begin
        if (rdy_seen[n]) begin
          rq_done[n] = 1'b1;
        end else begin
          if (rq_done[n]) begin
            rq_done[n] = 1'b0; rq_on[n] = 1'b0;
            set_req(n, 1'b0, 1'b0, '0, '0);
          end
          if (!rq_on[n] && $urandom_range(0, 2) == 0) begin
            logic w;
            w = 1'($urandom_range(0, 1));
            rq_on[n] = 1'b1;
            set_req(n, !w, w, $urandom, $urandom);
          end
        end
      end
      if (l2_read || l2_write) begin
        if (l2_wait < 0) l2_wait = $urandom_range(0, 3);
        if (l2_wait == 0) begin
          l2_ready = 1'b1; l2_wait = -1;
        end else begin
          l2_ready = 1'b0; l2_wait--;
        end
      end else begin
        l2_ready = ($urandom_range(0, 7) == 0);
      end
      l2_rdata = $urandom;
      l2_hit   = 1'($urandom_range(0, 1));
      @(negedge clk);
      rdy_seen[0] = r0_ready;
      rdy_seen[1] = r1_ready;
    end

    step();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
